// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO and a programmable bit divisor.
// Optional macro UART_TX_WAITREQ_EN: stall full-FIFO DATA writes instead of dropping them.
module uart_tx_periph #(
    parameter int FIFO_DEPTH  = 16,
    parameter int DEFAULT_DIV = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic        write,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteena,
    output logic        valid,
    output logic [31:0] rdata,
    output logic        waitrequest,
    output logic        txd,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   level_reg;
    logic          fifo_empty, fifo_full;

    logic [15:0]   baud_reg;
    logic          tx_en_reg, irq_en_reg, overflow_reg;

    state_t        state_reg, state_next;
    logic [15:0]   cnt_reg, cnt_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [7:0]    shift_reg, shift_next;
    logic          txd_reg, txd_next;

    logic          valid_reg;
    logic [31:0]   rdata_reg, rdata_mux;
    logic [7:0]    level8;

    logic          data_wr, push_req, push, pop, ovf_set, bit_last;
    logic [15:0]   div_load;
    logic          unused_bits;

    assign fifo_empty = (level_reg == '0);
    assign fifo_full  = level_reg[AW];          // level can only reach 2**AW when full
    assign level8     = 8'(level_reg);

    assign data_wr  = write && (addr == 2'd0);
    assign push_req = data_wr && byteena[0];
    assign bit_last = (cnt_reg == 16'd0);
    assign div_load = (baud_reg == 16'd0) ? 16'd0 : baud_reg - 16'd1;

`ifdef UART_TX_WAITREQ_EN
    assign waitrequest = data_wr && fifo_full && !pop;
    assign ovf_set     = 1'b0;
`else
    assign waitrequest = 1'b0;
    assign ovf_set     = push_req && fifo_full && !pop;
`endif
    // A pop in the same cycle frees the slot the push needs
    assign push = push_req && (!fifo_full || pop);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        pop          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (tx_en_reg && !fifo_empty) begin
                    pop        = 1'b1;
                    cnt_next   = div_load;
                    state_next = START;
                end
            end
            START: begin
                if (bit_last) begin
                    state_next   = DATA;
                    bit_idx_next = 3'd0;
                    cnt_next     = div_load;
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            DATA: begin
                if (bit_last) begin
                    cnt_next   = div_load;
                    shift_next = shift_reg >> 1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            STOP: begin
                if (bit_last) begin
                    if (tx_en_reg && !fifo_empty) begin
                        pop        = 1'b1;
                        cnt_next   = div_load;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // txd is registered from the next state so the line never glitches
    always_comb begin
        txd_next = 1'b1;
        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = shift_next[0];
            default: txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= 16'd0;
            bit_idx_reg <= 3'd0;
            shift_reg   <= 8'd0;
            txd_reg     <= 1'b1;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            txd_reg     <= txd_next;
            if (pop) begin
                shift_reg <= fifo_mem[rd_ptr_reg];
            end else begin
                shift_reg <= shift_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_reg     <= 16'(DEFAULT_DIV);
            tx_en_reg    <= 1'b1;
            irq_en_reg   <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (write) begin
                case (addr)
                    2'd1: if (wdata[3]) overflow_reg <= 1'b0;
                    2'd2: baud_reg <= wdata[15:0];
                    2'd3: begin
                        tx_en_reg  <= wdata[0];
                        irq_en_reg <= wdata[1];
                    end
                    default: ;
                endcase
            end
            if (ovf_set) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        rdata_mux = 32'd0;
        case (addr)
            2'd1:    rdata_mux = {16'd0, level8, 4'd0, overflow_reg, fifo_empty,
                                  fifo_full, (state_reg != IDLE)};
            2'd2:    rdata_mux = {16'd0, baud_reg};
            2'd3:    rdata_mux = {30'd0, irq_en_reg, tx_en_reg};
            default: rdata_mux = 32'd0;
        endcase
    end

    // A write in the same cycle suppresses the read response
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            rdata_reg <= 32'd0;
        end else begin
            valid_reg <= read && !write;
            rdata_reg <= (read && !write) ? rdata_mux : 32'd0;
        end
    end

    assign valid = valid_reg;
    assign rdata = rdata_reg;
    assign txd   = txd_reg;
    assign irq   = fifo_empty && (state_reg == IDLE) && irq_en_reg;

    assign unused_bits = &{1'b0, wdata[31:16], byteena[3:1]};
endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph: cycle-level model (byte queue + expected txd waveform) plus directed literal checks.
module tb_uart_tx_periph;
    localparam int DEPTH = 16;

    logic        clk, rst, read, write;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  byteena;
    logic        valid, waitrequest, txd, irq;
    logic [31:0] rdata;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_periph #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(434)) dut (
        .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr),
        .wdata(wdata), .byteena(byteena), .valid(valid), .rdata(rdata),
        .waitrequest(waitrequest), .txd(txd), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: bytes waiting, and the txd value for every remaining cycle of the frame in flight
    logic [7:0]  mq[$];
    bit          wave[$];
    logic [15:0] m_baud;
    bit          m_tx_en, m_irq_en, m_ovf, m_valid, model_ok = 0;
    logic [31:0] m_rdata;

    function automatic logic [31:0] m_reg(input logic [1:0] a);
        logic [31:0] r;
        r = 32'd0;
        case (a)
            2'd1: begin
                r[0]    = (wave.size() > 0);
                r[1]    = (mq.size() == DEPTH);
                r[2]    = (mq.size() == 0);
                r[3]    = m_ovf;
                r[15:8] = 8'(mq.size());
            end
            2'd2: r[15:0] = m_baud;
            2'd3: begin
                r[0] = m_tx_en;
                r[1] = m_irq_en;
            end
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // The transmitter takes a new byte when the current cycle is idle or the last of a frame
    function automatic bit m_popping();
        return (wave.size() <= 1) && m_tx_en && (mq.size() > 0);
    endfunction

    always @(posedge clk) begin : model_blk
        bit pop_now;
        int d;
        logic [7:0] b;
        if (rst) begin
            mq.delete();
            wave.delete();
            m_baud = 16'd434; m_tx_en = 1; m_irq_en = 0; m_ovf = 0;
            m_valid = 0; m_rdata = 32'd0; model_ok = 1;
        end else begin
            pop_now = m_popping();
            m_valid = read && !write;
            m_rdata = m_valid ? m_reg(addr) : 32'd0;
            if (wave.size() > 0) void'(wave.pop_front());
            if (pop_now) begin
                b = mq.pop_front();
                d = (m_baud == 16'd0) ? 1 : int'(m_baud);
                repeat (d) wave.push_back(1'b0);
                for (int k = 0; k < 8; k++) repeat (d) wave.push_back(b[k]);
                repeat (d) wave.push_back(1'b1);
            end
            if (write) begin
                case (addr)
                    2'd0: if (byteena[0]) begin
                        if (mq.size() < DEPTH) mq.push_back(wdata[7:0]);
`ifndef UART_TX_WAITREQ_EN
                        else m_ovf = 1;
`endif
                    end
                    2'd1: if (wdata[3]) m_ovf = 0;
                    2'd2: m_baud = wdata[15:0];
                    2'd3: begin
                        m_tx_en  = wdata[0];
                        m_irq_en = wdata[1];
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("txd", txd, (wave.size() > 0) ? wave[0] : 1'b1);
            check("irq", irq, (mq.size() == 0) && (wave.size() == 0) && m_irq_en);
            check("valid", valid, m_valid);
            check("rdata", rdata, m_rdata);
`ifdef UART_TX_WAITREQ_EN
            check("waitrequest", waitrequest,
                  write && (addr == 2'd0) && (mq.size() == DEPTH) && !m_popping());
`else
            check("waitrequest", waitrequest, 1'b0);
`endif
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, output int stalls);
        logic st;
        write = 1'b1; addr = a; wdata = d; byteena = 4'hF; stalls = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            st = waitrequest;
            @(posedge clk); #1;
            if (!st) break;
            stalls++;
        end
        if (stalls >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL write_accept: still stalled after %0d cycles, expected acceptance", stalls);
        end
        write = 1'b0; byteena = 4'h0;
        $display("write addr=%0d data=%08h stalls=%0d", a, d, stalls);
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string nm);
        read = 1'b1; addr = a;
        @(posedge clk); #1;
        read = 1'b0;
        check({nm, "_valid"}, valid, 1);
        check(nm, rdata, exp);
        $display("read  addr=%0d data=%08h expect=%08h", a, rdata, exp);
    endtask

    logic [9:0]  pat10;
    logic [39:0] pat40;

    initial begin
        int s;
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
        $fatal(1);
    end

    initial begin
        int s;
        rst = 1'b1; read = 0; write = 0; addr = 0; wdata = 0; byteena = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_txd", txd, 1);
        check("rst_irq", irq, 0);
        check("rst_valid", valid, 0);
        check("rst_waitreq", waitrequest, 0);
        bus_read(2'd1, 32'h0000_0004, "rst_status");
        bus_read(2'd2, 32'd434, "rst_baud");
        bus_read(2'd3, 32'h0000_0001, "rst_ctrl");

        // 0xA5 at divisor 4: start, 1,0,1,0,0,1,0,1, stop
        bus_write(2'd2, 32'd4, s);
        bus_write(2'd0, 32'hA5, s);
        check("a5_pre_idle", txd, 1);
        pat10 = 10'b1101001010;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            check("a5_bit", txd, pat10[i/4]);
            if (i == 10) begin read = 1'b1; addr = 2'd1; end
            if (i == 11) begin
                read = 1'b0;
                check("a5_busy_valid", valid, 1);
                check("a5_busy_status", rdata, 32'h0000_0005);
            end
        end
        @(posedge clk); #1;
        check("a5_post_idle", txd, 1);
        bus_read(2'd1, 32'h0000_0004, "a5_done_status");

        // Back-to-back 0x00 then 0xFF at divisor 2, irq enabled
        bus_write(2'd2, 32'd2, s);
        bus_write(2'd3, 32'd3, s);
        bus_write(2'd0, 32'h00, s);
        bus_write(2'd0, 32'hFF, s);
        pat40 = 40'hFF_FFCC_0000;
        for (int i = 0; i < 40; i++) begin
            check("b2b_bit", txd, pat40[i]);
            if (i == 20) check("b2b_irq_busy", irq, 0);
            @(posedge clk); #1;
        end
        check("b2b_irq_done", irq, 1);

        // Fill the FIFO with the transmitter disabled
        bus_write(2'd3, 32'd0, s);
        for (int i = 0; i < DEPTH; i++) bus_write(2'd0, 32'(i), s);
`ifndef UART_TX_WAITREQ_EN
        bus_write(2'd0, 32'h99, s);
        bus_read(2'd1, 32'h0000_100A, "full_ovf_status");
        bus_write(2'd1, 32'h8, s);
`endif
        bus_read(2'd1, 32'h0000_1002, "full_status");

        // Push in the same cycle the engine pops a full FIFO
        bus_write(2'd2, 32'd1, s);
        bus_write(2'd3, 32'd1, s);
        bus_write(2'd0, 32'h3C, s);
        bus_read(2'd1, 32'h0000_1003, "pushpop_status");
`ifdef UART_TX_WAITREQ_EN
        bus_write(2'd0, 32'h5A, s);
        check("wait_stalls", s, 8);
        bus_read(2'd1, 32'h0000_1003, "wait_status");
`else
        bus_write(2'd0, 32'h5A, s);
        bus_read(2'd1, 32'h0000_100B, "drop_status");
`endif

        // Reset in the middle of data bit 3
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus_write(2'd2, 32'd4, s);
        bus_write(2'd0, 32'hA5, s);
        repeat (18) begin @(posedge clk); #1; end
        check("rst_mid_bit3", txd, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_txd", txd, 1);
        bus_read(2'd1, 32'h0000_0004, "rst_mid_status");
        bus_read(2'd2, 32'd434, "rst_mid_baud");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_periph.md
Name: uart_tx_periph

Overview:
- Memory-mapped UART transmitter. It is a bus slave (responder) on the shared CPU bus, alongside data_ram and seg_periph.
- The CPU writes bytes into a TX FIFO. A baud-rate engine serialises them onto txd as 8N1 frames.
- Status and control are exposed through four 32-bit word registers, selected by the word-address bits from the bus.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries. Must be a power of two, at least 2.
- DEFAULT_DIV, 434, reset value of the BAUD register in clock cycles per bit (50 MHz / 115200).

Ports:
- clk  in  1  system clock (cpu_clk domain)
- rst  in  1  synchronous, active-high reset
- read  in  1  bus read strobe, already qualified with chip select
- write  in  1  bus write strobe, already qualified with chip select
- addr  in  2  register select = bus byte address [3:2]
- wdata  in  32  write data
- byteena  in  4  byte enables. Only byteena[0] gates DATA writes; other registers ignore byteena.
- valid  out  1  read-data-valid pulse
- rdata  out  32  read data
- waitrequest  out  1  slave stall
- txd  out  1  serial output, idle high
- irq  out  1  high while FIFO empty AND engine idle AND CTRL.irq_en

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high. On reset:
  - valid=0, rdata=0, waitrequest=0, txd=1, irq=0.
  - FIFO emptied; FSM in IDLE.
  - BAUD=DEFAULT_DIV; CTRL=0x1 (tx_en=1, irq_en=0); overflow flag cleared.
- Register map (addr):
  - 0 DATA: write pushes wdata[7:0] when byteena[0]=1. Read returns 0.
  - 1 STATUS (read): [0] busy (FSM not IDLE), [1] full, [2] empty, [3] overflow (sticky), [15:8] FIFO level, others 0. Write with wdata[3]=1 clears overflow; other bits ignored.
  - 2 BAUD: [15:0] divisor, read/write. Upper bits read 0.
  - 3 CTRL: [0] tx_en, [1] irq_en, read/write. Upper bits read 0.
- Read handshake:
  - A read in cycle N gives valid=1 in cycle N+1, with registered rdata (value as of cycle N).
  - valid is a single-cycle pulse per read.
  - Writes produce no valid.
  - read and write never both asserted in one cycle; if they are, write wins and no valid is produced.
- FIFO:
  - Circular buffer with wrap-around read/write pointers; level width is log2(FIFO_DEPTH)+1.
  - Push when full (without the macro): data dropped, overflow set to 1, waitrequest stays 0.
  - Simultaneous push and pop when full: the pop frees a slot and the push is accepted, with no overflow.
  - Simultaneous push and pop when empty: the pop does not occur; the push is accepted.
- Bit timing:
  - Effective divisor D = max(BAUD,1).
  - Each bit holds txd for exactly D cycles. A down-counter is loaded with D-1 at every bit start.
  - A BAUD change takes effect at the next bit boundary; the current bit is unaffected.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if tx_en=1 and FIFO not empty, pop the head into the shift register and go to START. txd=0 from the next cycle.
  - START: txd=0 for D cycles, then DATA with bit index 0.
  - DATA: txd=shift[0] (LSB first), D cycles per bit, shift right. After bit 7 go to STOP.
  - STOP: txd=1 for D cycles. At the end:
    - if tx_en and FIFO not empty, pop and go directly to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
  - Frame length is exactly 10·D cycles.
- Clearing tx_en mid-frame: the current frame completes. No new pop occurs until tx_en=1.
- Reset mid-frame: txd returns to 1 on the next cycle; the frame is abandoned and the FIFO contents are lost.

Optional Feature:
- Macro: UART_TX_WAITREQ_EN.
- Defined:
  - A DATA write while the FIFO is full asserts waitrequest combinationally in the same cycle.
  - waitrequest stays high while write, addr=0 and full persist.
  - The write is accepted in the first cycle a slot frees (pop in the same cycle counts as a free slot).
  - overflow is never set by pushes.
- Undefined: waitrequest is tied to 0, and drop-plus-overflow behaviour applies.

Test Plan:
- Reset, then read addr 1 → valid one cycle later. rdata=0x00000004 (empty, idle), txd=1, BAUD reads 434.
- Write BAUD=4, write DATA=0xA5 → txd shows start 0, then bits 1,0,1,0,0,1,0,1, then stop 1. Each bit lasts 4 cycles; frame totals 40 cycles; STATUS.busy=1 during the frame.
- BAUD=2, push 0x00 then 0xFF → second start bit begins in the cycle right after the first stop bit ends (no idle gap); irq=1 after both frames if irq_en=1.
- tx_en=0, push 17 bytes (FIFO_DEPTH=16) → STATUS level=16, full=1, overflow=1. Write STATUS wdata=0x8 → overflow=0.
- With UART_TX_WAITREQ_EN and FIFO full at BAUD=1: write DATA=0x3C → waitrequest held high until the FSM pops, then the write completes, with overflow still 0.
- Assert rst during DATA bit 3 → next cycle txd=1, STATUS=0x00000004, BAUD=434.
